// File: rtl/shift_reg_ctrl_pkg.sv
// Shared definitions for the serial shift-register sequencer.
//   state_e    : FSM state encodings (IDLE=0, SHIFT=1, GAP=2)
//   gap_cnt_w  : width of the inter-word gap counter for a given gap length
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Gap counter holds GAP_CYCLES-1 down to 0; keep at least one bit.
  function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
    return (gap_cycles < 2) ? 1 : $clog2(gap_cycles);
  endfunction

endpackage : shift_reg_ctrl_pkg

// File: rtl/shift_reg_ctrl_if.sv
// Word-level valid/ready handshake between a producer and the sequencer.
//   in_valid : producer has a word on in_data
//   in_data  : parallel word, WIDTH bits
//   in_ready : sequencer accepts in_data this cycle
// Modports: master = producer side, slave = sequencer side.
interface shift_reg_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface : shift_reg_ctrl_if

// File: rtl/shift_reg_core.sv
// WIDTH-bit parallel-load shift register with a single serial tap.
//   clock, reset_n : clock and async active-low clear
//   load           : capture din (takes priority over shift_en)
//   shift_en       : move one position toward the serial tap
//   din            : parallel word
//   ser_out        : current serial bit (MSB when MSB_FIRST != 0, else LSB)
module shift_reg_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             ser_out
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  // Direction is fixed at elaboration; vacated positions fill with zero.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign shifted = {sreg[WIDTH-2:0], 1'b0};
    assign ser_out = sreg[WIDTH-1];
  end else begin : g_lsb_first
    assign shifted = {1'b0, sreg[WIDTH-1:1]};
    assign ser_out = sreg[0];
  end

  // Storage register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      sreg <= shifted;
    end
  end

endmodule : shift_reg_core

// File: rtl/shift_reg_ctrl.sv
// Sequencer for a bit-serial datapath: accepts words over a valid/ready handshake,
// shifts them out one bit per clock and optionally forces idle gaps between words.
//   clock, reset_n : clock and async active-low reset
//   enable         : permits acceptance of new words
//   in_if          : word handshake (slave side; in_ready is combinational)
//   ser_out        : current serial bit
//   ser_valid      : ser_out carries a valid bit
//   bit_cnt        : bits remaining after the current one (WIDTH-1 .. 0)
//   busy           : FSM not in IDLE
//   done           : one-cycle pulse in the cycle after a word's last bit
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  shift_reg_ctrl_if.slave          in_if,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = gap_cnt_w(GAP_CYCLES);
  localparam bit          CHAIN = (GAP_CYCLES == 0);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_nxt;
  logic               done_nxt;
  logic               load;
  logic               shift_en;
  logic               last_bit;
  logic               ready_c;
  logic               accept;

  assign last_bit = (state == SHIFT) && (bit_cnt == '0);

  // Ready in IDLE, or in the last bit cycle when words may be chained.
  assign ready_c = reset_n && enable &&
                   ((state == IDLE) || (CHAIN && last_bit));
  assign in_if.in_ready = ready_c;
  assign accept         = in_if.in_valid && ready_c;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter and datapath control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(WIDTH - 1);
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt == '0) begin
          done_nxt = 1'b1;
          if (accept) begin
            // Reload in place: next word's first bit follows with no bubble.
            load    = 1'b1;
            cnt_nxt = CNT_W'(WIDTH - 1);
          end else begin
            shift_en = 1'b1;
            if (CHAIN) begin
              state_nxt = IDLE;
            end else begin
              gap_nxt   = GAP_W'(GAP_CYCLES - 1);
              state_nxt = GAP;
            end
          end
        end else begin
          shift_en = 1'b1;
          cnt_nxt  = bit_cnt - CNT_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered status outputs and counters, derived from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bit_cnt   <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      done      <= done_nxt;
      ser_valid <= (state_nxt == SHIFT);
      busy      <= (state_nxt != IDLE);
    end
  end

  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .din      (in_if.in_data),
    .ser_out  (ser_out)
  );

endmodule : shift_reg_ctrl

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl. Three instances share clock and reset:
//   a: GAP_CYCLES=0, MSB_FIRST=1   b: GAP_CYCLES=3, MSB_FIRST=1
//   c: GAP_CYCLES=0, MSB_FIRST=0
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs of the selected instance compared 1ns later.
module tb_shift_reg_ctrl;

  logic clock;
  logic reset_n;
  logic en_a, en_b, en_c;
  logic so_a, so_b, so_c;
  logic sv_a, sv_b, sv_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  shift_reg_ctrl_if #(.WIDTH(8)) if_a ();
  shift_reg_ctrl_if #(.WIDTH(8)) if_b ();
  shift_reg_ctrl_if #(.WIDTH(8)) if_c ();

  shift_reg_ctrl #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .in_if(if_a),
    .ser_out(so_a), .ser_valid(sv_a), .bit_cnt(cnt_a), .busy(busy_a), .done(done_a));

  shift_reg_ctrl #(.WIDTH(8), .GAP_CYCLES(3), .MSB_FIRST(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .in_if(if_b),
    .ser_out(so_b), .ser_valid(sv_b), .bit_cnt(cnt_b), .busy(busy_b), .done(done_b));

  shift_reg_ctrl #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .enable(en_c), .in_if(if_c),
    .ser_out(so_c), .ser_valid(sv_c), .bit_cnt(cnt_c), .busy(busy_c), .done(done_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int         tst;
    int         sel;
    logic       rst_n;
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       so;
    logic       sv;
    logic [2:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int tst, input int sel, input logic rst_n, input logic en,
                     input logic vld, input logic [7:0] data, input logic rdy,
                     input logic so, input logic sv, input logic [2:0] cnt,
                     input logic busy, input logic done);
    vec_t v;
    v.tst = tst; v.sel = sel; v.rst_n = rst_n; v.en = en; v.vld = vld; v.data = data;
    v.rdy = rdy; v.so = so; v.sv = sv; v.cnt = cnt; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic chk(input int tst, input int idx, input string nm,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL t%0d.%0d %s: got %0h, expected %0h", tst, idx, nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
    if_b.in_valid = 1'b0; if_b.in_data = 8'h00;
    if_c.in_valid = 1'b0; if_c.in_data = 8'h00;
  endtask

  task automatic apply(input vec_t v);
    idle_inputs();
    reset_n = v.rst_n;
    case (v.sel)
      0: begin en_a = v.en; if_a.in_valid = v.vld; if_a.in_data = v.data; end
      1: begin en_b = v.en; if_b.in_valid = v.vld; if_b.in_data = v.data; end
      default: begin en_c = v.en; if_c.in_valid = v.vld; if_c.in_data = v.data; end
    endcase
  endtask

  task automatic compare(input vec_t v, input int idx);
    logic rdy, so, sv, busy, done;
    logic [2:0] cnt;
    case (v.sel)
      0: begin rdy = if_a.in_ready; so = so_a; sv = sv_a; cnt = cnt_a; busy = busy_a; done = done_a; end
      1: begin rdy = if_b.in_ready; so = so_b; sv = sv_b; cnt = cnt_b; busy = busy_b; done = done_b; end
      default: begin rdy = if_c.in_ready; so = so_c; sv = sv_c; cnt = cnt_c; busy = busy_c; done = done_c; end
    endcase
    chk(v.tst, idx, "in_ready",  8'(rdy),  8'(v.rdy));
    chk(v.tst, idx, "ser_out",   8'(so),   8'(v.so));
    chk(v.tst, idx, "ser_valid", 8'(sv),   8'(v.sv));
    chk(v.tst, idx, "bit_cnt",   8'(cnt),  8'(v.cnt));
    chk(v.tst, idx, "busy",      8'(busy), 8'(v.busy));
    chk(v.tst, idx, "done",      8'(done), 8'(v.done));
  endtask

  task automatic fill_table();
    logic [7:0] w;
    // 1: reset holds everything low even with enable and in_valid high
    add(1, 0, 0, 1, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // 2: A5 MSB first, done one cycle after the last bit
    w = 8'hA5;
    add(2, 0, 1, 1, 1, w, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(2, 0, 1, 1, 0, 8'h00, (i == 7), w[7-i], 1, 3'(7 - i), 1, 0);
    add(2, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    // 3: FF then 00 chained back-to-back
    add(3, 0, 1, 1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(3, 0, 1, 1, 1, 8'h00, (i == 7), 1, 1, 3'(7 - i), 1, 0);
    for (int i = 0; i < 8; i++)
      add(3, 0, 1, 1, 0, 8'h00, (i == 7), 0, 1, 3'(7 - i), 1, (i == 0));
    add(3, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    add(3, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // 4: GAP_CYCLES=3, two words 81 with in_valid held
    w = 8'h81;
    add(4, 1, 1, 1, 1, w, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(4, 1, 1, 1, 1, w, 0, w[7-i], 1, 3'(7 - i), 1, 0);
    for (int j = 0; j < 3; j++)
      add(4, 1, 1, 1, 1, w, 0, 0, 0, 0, 1, (j == 0));
    add(4, 1, 1, 1, 1, w, 1, 0, 0, 0, 0, 0);
    add(4, 1, 1, 1, 0, 8'h00, 0, 1, 1, 7, 1, 0);
    // 5: LSB first, enable dropped at bit 3, held-valid word waits for enable
    add(5, 2, 1, 1, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(5, 2, 1, (i < 2), 1, 8'hFF, 0, (i == 0), 1, 3'(7 - i), 1, 0);
    add(5, 2, 1, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 1);
    add(5, 2, 1, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
    add(5, 2, 1, 1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    add(5, 2, 1, 1, 0, 8'h00, 0, 1, 1, 7, 1, 0);
  endtask

  initial begin
    logic [7:0] w;
    reset_n = 1'b0;
    idle_inputs();
    fill_table();

    foreach (vecs[i]) begin
      @(negedge clock);
      apply(vecs[i]);
      #1;
      compare(vecs[i], i);
    end

    // 6: async reset pulse during bit 4 of C3, then 3C from a clean start
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    if_a.in_valid = 1'b1; if_a.in_data = 8'hC3;
    #1 chk(6, 0, "in_ready", 8'(if_a.in_ready), 8'd1);
    w = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
      #1;
      chk(6, 1 + k, "bit_cnt", 8'(cnt_a), 8'(7 - k));
      chk(6, 1 + k, "ser_out", 8'(so_a), 8'(w[7-k]));
    end
    reset_n = 1'b0;
    #1;
    chk(6, 10, "rst ser_out",   8'(so_a),          8'd0);
    chk(6, 10, "rst ser_valid", 8'(sv_a),          8'd0);
    chk(6, 10, "rst bit_cnt",   8'(cnt_a),         8'd0);
    chk(6, 10, "rst busy",      8'(busy_a),        8'd0);
    chk(6, 10, "rst done",      8'(done_a),        8'd0);
    chk(6, 10, "rst in_ready",  8'(if_a.in_ready), 8'd0);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      chk(6, 20 + k, "no done", 8'(done_a), 8'd0);
      chk(6, 20 + k, "idle busy", 8'(busy_a), 8'd0);
    end
    @(negedge clock);
    if_a.in_valid = 1'b1; if_a.in_data = 8'h3C;
    #1 chk(6, 30, "in_ready", 8'(if_a.in_ready), 8'd1);
    w = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
      #1;
      chk(6, 31 + k, "bit_cnt",   8'(cnt_a), 8'(7 - k));
      chk(6, 31 + k, "ser_out",   8'(so_a),  8'(w[7-k]));
      chk(6, 31 + k, "ser_valid", 8'(sv_a),  8'd1);
    end
    @(negedge clock);
    #1;
    chk(6, 40, "done", 8'(done_a), 8'd1);
    chk(6, 40, "busy", 8'(busy_a), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_reg_ctrl
